ps2_receiver: RTL and testbench

- Front end of the keyboard input path. Deserialises PS/2 device-to-host frames from the raw PS2_CLK/PS2_DAT pins into 8-bit scan codes.
- Outputs a one-cycle data_en strobe with each code. This drives the data/data_en inputs of the loop, tempo and pattern input controllers.
- Scan codes pass through unfiltered: make codes, 0xF0 break prefix, 0xE0 extended prefix. Interpretation belongs downstream.
- Flags malformed frames on frame_err and discards them.

---
 rtl/ps2_receiver.sv | 131 +++++++++++++
 tb/tb_ps2_receiver.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: synchronises the raw pins and deserialises
// 11-bit frames into 8-bit scan codes with one-cycle data_en / frame_err strobes.
module ps2_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] data,
  output logic       data_en,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_reg, dat_sync_reg;
  logic                   clk_prev_reg;
  logic                   clk_sync, dat_sync, fall, frame_ok;

  state_t        state_reg, state_next;
  logic [2:0]    bitcnt_reg, bitcnt_next;
  logic [7:0]    sr_reg, sr_next;
  logic          par_reg, par_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [7:0]    data_reg, data_next;
  logic          data_en_reg, data_en_next;
  logic          frame_err_reg, frame_err_next;

  // Synchronisers reset to idle-high so reset release never looks like a falling edge
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      clk_sync_reg <= '1;
      dat_sync_reg <= '1;
      clk_prev_reg <= 1'b1;
    end else begin
      clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], PS2_DAT};
      clk_prev_reg <= clk_sync;
    end
  end

  assign clk_sync = clk_sync_reg[SYNC_STAGES-1];
  assign dat_sync = dat_sync_reg[SYNC_STAGES-1];
  assign fall     = clk_prev_reg & ~clk_sync;
  assign frame_ok = dat_sync & (^sr_reg ^ par_reg);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg     <= IDLE;
      bitcnt_reg    <= '0;
      sr_reg        <= '0;
      par_reg       <= 1'b0;
      timer_reg     <= '0;
      data_reg      <= '0;
      data_en_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bitcnt_reg    <= bitcnt_next;
      sr_reg        <= sr_next;
      par_reg       <= par_next;
      timer_reg     <= timer_next;
      data_reg      <= data_next;
      data_en_reg   <= data_en_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bitcnt_next    = bitcnt_reg;
    sr_next        = sr_reg;
    par_next       = par_reg;
    timer_next     = timer_reg;
    data_next      = data_reg;
    data_en_next   = 1'b0;
    frame_err_next = 1'b0;

    // A falling edge takes priority over a coincident timeout expiry
    if (fall) begin
      timer_next = '0;
      case (state_reg)
        IDLE: begin
          if (!dat_sync) begin
            state_next  = DATA;
            bitcnt_next = '0;
          end
        end
        DATA: begin
          sr_next     = {dat_sync, sr_reg[7:1]};
          bitcnt_next = bitcnt_reg + 3'd1;
          if (bitcnt_reg == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          par_next   = dat_sync;
          state_next = STOP;
        end
        STOP: begin
          if (frame_ok) begin
            data_next    = sr_reg;
            data_en_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE) begin
      if (timer_reg == TIMER_MAX) begin
        state_next  = IDLE;
        bitcnt_next = '0;
        timer_next  = '0;
      end else begin
        timer_next = timer_reg + TW'(1);
      end
    end else begin
      timer_next = '0;
    end
  end

  assign data      = data_reg;
  assign data_en   = data_en_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed and randomized PS/2 frames checked against a frame-level reference model.
module tb_ps2_receiver;

  localparam int SYNC = 2;
  localparam int TMO  = 200;

  logic       Clock   = 1'b0;
  logic       nReset  = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] data;
  logic       data_en, frame_err;

  always #5 Clock = ~Clock;

  ps2_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock(Clock), .nReset(nReset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .data(data), .data_en(data_en), .frame_err(frame_err)
  );

  typedef struct packed {logic err; logic [7:0] d;} ev_t;
  ev_t        ev_q[$];
  int         n_cmp = 0, n_bad = 0;
  int         cyc = 0, stop_fall_cyc = 0, last_lat = 0, viol = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] exp_data = 8'h00;

  always @(posedge Clock) cyc++;

  // Collect strobes; protocol violations are tallied and checked after each frame
  always @(negedge Clock) begin
    if (nReset) begin
      if (data_en) begin
        ev_q.push_back('{err: 1'b0, d: data});
        last_lat = cyc - stop_fall_cyc;
      end
      if (frame_err) ev_q.push_back('{err: 1'b1, d: 8'h00});
      if (data_en && frame_err) viol++;
      if ((data_en || frame_err) && prev_strobe) viol++;
      prev_strobe = data_en | frame_err;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Bits go out LSB first; data is set up while PS2_CLK is high
  task automatic send(input logic [10:0] bits, input int nbits, input int half,
                      input int gap_idx, input int gap_len);
    for (int i = 0; i < nbits; i++) begin
      PS2_DAT = bits[i];
      wait_cyc(half);
      PS2_CLK = 1'b0;
      if (i == 10) stop_fall_cyc = cyc;
      wait_cyc(half);
      PS2_CLK = 1'b1;
      if (i == gap_idx) wait_cyc(gap_len);
    end
    PS2_DAT = 1'b1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {stop, par, b, 1'b0};
  endfunction

  // Reference rule: start 0, stop 1, and an odd number of ones over data+parity
  function automatic bit frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (($countones(f[9:1]) % 2) == 1);
  endfunction

  task automatic check_events(input bit exp_v, input bit exp_e, input string tag);
    chk({tag, ":nevents"}, ev_q.size(), (exp_v || exp_e) ? 1 : 0);
    if (ev_q.size() > 0) begin
      chk({tag, ":kind_err"}, ev_q[0].err, exp_e);
      if (exp_v) chk({tag, ":strobe_data"}, ev_q[0].d, exp_data);
    end
    if (exp_v) chk({tag, ":latency_ok"}, (last_lat >= SYNC && last_lat <= SYNC + 2), 1);
    chk({tag, ":data"}, data, exp_data);
    chk({tag, ":protocol_viol"}, viol, 0);
    ev_q.delete();
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit stop,
                       input int half, input string tag);
    logic [10:0] f;
    bit          ok;
    f  = mk(b, bad_par, stop);
    ok = frame_ok(f);
    send(f, 11, half, -1, 0);
    wait_cyc(8);
    if (ok) exp_data = b;
    $display("frame %s: byte=%02h bad_par=%0d stop=%0d half=%0d expect %s",
             tag, b, bad_par, stop, half, ok ? "data" : "err");
    check_events(ok, !ok, tag);
  endtask

  initial begin
    wait_cyc(5);
    chk("reset:data", data, 8'h00);
    chk("reset:data_en", data_en, 1'b0);
    chk("reset:frame_err", frame_err, 1'b0);
    nReset = 1'b1;
    wait_cyc(5);
    chk("post_reset:data", data, 8'h00);

    frame(8'h16, 0, 1, 20, "valid_16");
    frame(8'hF0, 0, 1, 20, "b2b_F0");
    frame(8'h5A, 0, 1, 20, "b2b_5A");
    frame(8'h1E, 1, 1, 20, "badpar_1E");
    frame(8'h26, 0, 0, 20, "badstop_26");
    frame(8'h45, 0, 1, 20, "valid_45");

    // Partial frame abandoned by timeout
    send(mk(8'hA5, 0, 1), 5, 20, -1, 0);
    wait_cyc(TMO + 10);
    $display("frame tmo_partial: 5 bits then idle %0d cycles", TMO + 10);
    check_events(0, 0, "tmo_partial");
    frame(8'h66, 0, 1, 20, "after_tmo_66");

    // Inter-bit gap just short of the timeout must not abort the frame
    send(mk(8'h29, 0, 1), 11, 20, 4, TMO - 60);
    wait_cyc(8);
    exp_data = 8'h29;
    $display("frame gap_29: gap of %0d cycles between falls", TMO - 20);
    check_events(1, 0, "gap_29");

    // Reset mid-frame
    send(mk(8'h3D, 0, 1), 5, 20, -1, 0);
    @(negedge Clock);
    #2 nReset = 1'b0;
    wait_cyc(3);
    exp_data = 8'h00;
    chk("midreset:data", data, 8'h00);
    chk("midreset:data_en", data_en, 1'b0);
    chk("midreset:frame_err", frame_err, 1'b0);
    nReset = 1'b1;
    wait_cyc(5);
    $display("reset mid-frame 3D: released");
    check_events(0, 0, "midreset");
    frame(8'h3E, 0, 1, 20, "after_reset_3E");

    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      int         k, half;
      b    = 8'($urandom);
      k    = $urandom_range(0, 5);
      half = $urandom_range(8, 30);
      frame(b, k == 4, k != 5, half, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
